shift_capture_ctrl: RTL

Sequencer for the 8-bit serial-in shift register in the serial datapath. It accepts a start request and gates serial bit strobes into the register's shift enable. It counts WIDTH bits, snapshots the register's parallel output and presents the word on a valid/ready interface. It aborts a frame when the bit stream stalls too long.

---
 rtl/shift_capture_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/shift_capture_ctrl.sv
// Purpose: sequences one WIDTH-bit frame into an external left-shift register, snapshots it and offers the word downstream.
// Latency: out_valid rises one cycle after the edge that shifts in the last bit; abort fires GAP_MAX idle cycles after the last bit.
// Backpressure: out_valid/out_data are held until out_ready; bits arriving while a word waits are dropped and flagged by overrun.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   start             - frame request, sampled every cycle in IDLE and on the DELIVER handshake
//   bit_valid, bit_in - serial bit strobe and data
//   sr_data           - parallel output of the attached shift register
//   shift_enable      - shift strobe to the register (only in SHIFT)
//   shift_data        - serial data to the register (pass-through)
//   out_data/out_valid/out_ready - captured word, valid/ready handshake
//   busy              - controller is not idle
//   abort             - one-cycle pulse when a frame is dropped on a gap timeout
//   overrun           - one-cycle pulse per bit dropped while a word is pending
module shift_capture_ctrl #(
    parameter int WIDTH   = 8,
    parameter int GAP_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] sr_data,
    output logic             shift_enable,
    output logic             shift_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             abort,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_DELIVER
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               abort_q, abort_d;
    logic               overrun_q, overrun_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        abort_d     = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // bit_valid is deliberately ignored here: no shift, no overrun.
                if (start) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                // A bit arriving on the final gap cycle takes priority over the timeout.
                if (bit_valid) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    gap_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_CAPTURE;
                    end
                end else if (gap_cnt_q == GAP_LAST) begin
                    // Partial frame stays in the register; the next frame shifts WIDTH fresh bits over it.
                    state_d   = ST_IDLE;
                    abort_d   = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            ST_CAPTURE: begin
                // Register has been frozen since the last bit, so sr_data is the complete frame.
                out_data_d  = sr_data;
                out_valid_d = 1'b1;
                overrun_d   = bit_valid;
                state_d     = ST_DELIVER;
            end

            ST_DELIVER: begin
                overrun_d = bit_valid;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (start) begin
                        // Back-to-back frame: skip IDLE entirely.
                        state_d   = ST_SHIFT;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign shift_enable = (state_q == ST_SHIFT) && bit_valid;
    assign shift_data   = bit_in;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign abort        = abort_q;
    assign overrun      = overrun_q;

endmodule
